// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Bundle of the IFU, LSU and downstream memory signals around the
//            shared memory-port arbiter. The slave modport is the arbiter's
//            view; the master modport is the view of the surrounding core.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  // Instruction-fetch side
  logic              ifu_req;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_flush;
  logic              ifu_ready;
  logic              ifu_rvalid;
  logic [DATA_W-1:0] ifu_rdata;

  // Load/store side
  logic              lsu_req;
  logic              lsu_wen;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_ready;
  logic              lsu_rvalid;
  logic [DATA_W-1:0] lsu_rdata;

  // Downstream memory port
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  // Status towards the pipeline controller
  logic              bus_err;
  logic              if_stall;
  logic              mem_stall;

  modport slave (
    input  ifu_req, ifu_addr, ifu_flush,
    output ifu_ready, ifu_rvalid, ifu_rdata,
    input  lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    output lsu_ready, lsu_rvalid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output bus_err, if_stall, mem_stall
  );

  modport master (
    output ifu_req, ifu_addr, ifu_flush,
    input  ifu_ready, ifu_rvalid, ifu_rdata,
    output lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
    input  lsu_ready, lsu_rvalid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  bus_err, if_stall, mem_stall
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Single-outstanding arbiter of the shared memory port between the
//            IFU and LSU. LSU has fixed priority. IDLE/REQ/WAIT sequencing,
//            IFU flush/drop handling and pipeline stall generation.
//            Optional watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int MASK_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              owner;     // 0 = IFU, 1 = LSU
  logic              drop;      // IFU response must be swallowed
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;

  logic busy;
  logic grant_lsu;
  logic grant_ifu;
  logic handshake;
  logic resp_done;
  logic abort;
  logic finish;

  assign busy      = (state != S_IDLE);
  assign grant_lsu = (state == S_IDLE) && bus.lsu_req;
  assign grant_ifu = (state == S_IDLE) && !bus.lsu_req && bus.ifu_req;
  assign handshake = (state == S_REQ) && bus.mem_req_ready;
  // Responses are only meaningful in WAIT; anything seen in IDLE/REQ is stale.
  assign resp_done = (state == S_WAIT) && bus.mem_resp_valid;
  assign finish    = resp_done || abort;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;

  // Watchdog: restarts on every grant, counts each busy cycle
  always_ff @(posedge clk) begin
    if (rst || grant_lsu || grant_ifu) cnt <= '0;
    else if (busy)                     cnt <= cnt + CNT_W'(1);
  end

  // Fires in the cycle the count reaches TIMEOUT; a same-cycle response wins.
  assign abort = busy && (cnt == CNT_W'(TIMEOUT - 1)) && !resp_done;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign abort          = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_lsu || grant_ifu) state_nxt = S_REQ;
      S_REQ:   if (abort) state_nxt = S_IDLE;
               else if (handshake) state_nxt = S_WAIT;
      S_WAIT:  if (finish) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Payload capture on grant, owner tracking and flush/drop bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      owner   <= 1'b0;
      drop    <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (grant_lsu) begin
      owner   <= 1'b1;
      drop    <= 1'b0;
      addr_q  <= bus.lsu_addr;
      wen_q   <= bus.lsu_wen;
      wdata_q <= bus.lsu_wdata;
      wmask_q <= bus.lsu_wmask;
    end else if (grant_ifu) begin
      owner   <= 1'b0;
      drop    <= 1'b0;
      addr_q  <= bus.ifu_addr;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (finish) begin
      drop    <= 1'b0;
    end else if (busy && !owner && bus.ifu_flush) begin
      drop    <= 1'b1;
    end
  end

  // Outputs: grants, memory request, completion pass-through and stalls
  always_comb begin
    bus.ifu_ready     = !rst && grant_ifu;
    bus.lsu_ready     = !rst && grant_lsu;
    bus.mem_req_valid = !rst && (state == S_REQ);
    bus.mem_addr      = addr_q;
    bus.mem_wen       = wen_q;
    bus.mem_wdata     = wdata_q;
    bus.mem_wmask     = wmask_q;
    bus.bus_err       = !rst && abort;
    bus.lsu_rvalid    = !rst && finish && owner;
    // A flush arriving together with the response still kills it.
    bus.ifu_rvalid    = !rst && finish && !owner && !drop && !bus.ifu_flush;
    // Aborted transactions complete with zero data.
    bus.lsu_rdata     = (bus.lsu_rvalid && resp_done) ? bus.mem_rdata : '0;
    bus.ifu_rdata     = (bus.ifu_rvalid && resp_done) ? bus.mem_rdata : '0;
    bus.if_stall      = (bus.ifu_req || (busy && !owner && !drop)) && !bus.ifu_rvalid;
    bus.mem_stall     = (bus.lsu_req || (busy && owner)) && !bus.lsu_rvalid;
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter: table of transactions plus
//            hand-written priority, flush, reset and watchdog sequences, with
//            a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   passed;
  int   total;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          lsu;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          rdy_dly;
    int          rsp_dly;
    logic [31:0] rdata;
    bit          exp_wen;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    bit          lsu;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  exp_t e;

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input bit lsu, input logic [31:0] data);
    exp_t x;
    x.lsu  = lsu;
    x.data = data;
    sb.push_back(x);
  endtask

  // Scoreboard: every completion pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (!bus.ifu_rvalid) check32("ifu_rdata_zero", bus.ifu_rdata, 32'h0);
      if (!bus.lsu_rvalid) check32("lsu_rdata_zero", bus.lsu_rdata, 32'h0);
      if (bus.ifu_rvalid || bus.lsu_rvalid) begin
        if (sb.size() == 0) begin
          check1("sb_unexpected_rvalid", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check1("sb_port_lsu", bus.lsu_rvalid, e.lsu);
          check32("sb_rdata", e.lsu ? bus.lsu_rdata : bus.ifu_rdata, e.data);
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.ifu_req        = 1'b0;
    bus.ifu_addr       = '0;
    bus.ifu_flush      = 1'b0;
    bus.lsu_req        = 1'b0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wdata      = '0;
    bus.lsu_wmask      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  // One complete transaction with programmable ready/response delays
  task automatic run_txn(input vec_t v);
    bit got;
    got = 1'b0;
    if (v.lsu) begin
      bus.lsu_req   = 1'b1;
      bus.lsu_wen   = v.wen;
      bus.lsu_addr  = v.addr;
      bus.lsu_wdata = v.wdata;
      bus.lsu_wmask = v.wmask;
    end else begin
      bus.ifu_req  = 1'b1;
      bus.ifu_addr = v.addr;
    end
    for (int n = 0; n < 16 && !got; n++) begin
      @(negedge clk);
      got = v.lsu ? bus.lsu_ready : bus.ifu_ready;
      if (!got) tick();
    end
    check1("grant", got, 1'b1);
    if (!got) begin
      tick();
      clear_inputs();
      return;
    end
    check1("grant_stall", v.lsu ? bus.mem_stall : bus.if_stall, 1'b1);
    expect_resp(v.lsu, v.rdata);
    tick();
    bus.lsu_req = 1'b0;
    bus.ifu_req = 1'b0;
    for (int d = 0; d <= v.rdy_dly; d++) begin
      bus.mem_req_ready = (d == v.rdy_dly);
      @(negedge clk);
      check1("req_valid", bus.mem_req_valid, 1'b1);
      check32("req_addr", bus.mem_addr, v.addr);
      check1("req_wen", bus.mem_wen, v.exp_wen);
      check32("req_wmask", {28'h0, bus.mem_wmask}, {28'h0, v.exp_wmask});
      if (v.lsu) check32("req_wdata", bus.mem_wdata, v.exp_wdata);
      check1("req_stall", v.lsu ? bus.mem_stall : bus.if_stall, 1'b1);
      tick();
    end
    bus.mem_req_ready = 1'b0;
    for (int d = 0; d <= v.rsp_dly; d++) begin
      bus.mem_resp_valid = (d == v.rsp_dly);
      bus.mem_rdata      = (d == v.rsp_dly) ? v.rdata : 32'hFFFF_FFFF;
      @(negedge clk);
      check1("rvalid_timing", v.lsu ? bus.lsu_rvalid : bus.ifu_rvalid, d == v.rsp_dly);
      check1("wait_stall", v.lsu ? bus.mem_stall : bus.if_stall, d != v.rsp_dly);
      tick();
    end
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    passed = 0;
    total  = 0;
    clear_inputs();
    rst = 1'b1;
    bus.ifu_req = 1'b1;
    bus.lsu_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check1("rst_ifu_ready", bus.ifu_ready, 1'b0);
    check1("rst_lsu_ready", bus.lsu_ready, 1'b0);
    check1("rst_req_valid", bus.mem_req_valid, 1'b0);
    check32("rst_mem_addr", bus.mem_addr, 32'h0);
    check1("rst_bus_err", bus.bus_err, 1'b0);
    check1("rst_mem_stall", bus.mem_stall, 1'b1);
    tick();
    rst = 1'b0;
    clear_inputs();

    // lsu, wen, addr, wdata, wmask, rdy_dly, rsp_dly, rdata, exp_wen, exp_wmask, exp_wdata
    vecs[0] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0,         4'h0, 0, 0, 32'h0000_0413, 1'b0, 4'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_2000, 32'hFFFF_FFFF, 4'hF, 1, 2, 32'hCAFE_F00D, 1'b0, 4'hF, 32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 1, 32'h0,         1'b1, 4'hF, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b1, 32'h8000_0004, 32'h0000_1234, 4'hF, 5, 0, 32'h0000_0513, 1'b0, 4'h0, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_1004, 32'h0000_BEEF, 4'h3, 2, 3, 32'h0,         1'b1, 4'h3, 32'h0000_BEEF};
    vecs[5] = '{1'b0, 1'b0, 32'h8000_0008, 32'h0,         4'h0, 0, 4, 32'h0010_0093, 1'b0, 4'h0, 32'h0};
    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Simultaneous requests: LSU first, IFU granted in the IDLE after lsu_rvalid
    bus.ifu_req   = 1'b1;
    bus.ifu_addr  = 32'h8000_0100;
    bus.lsu_req   = 1'b1;
    bus.lsu_wen   = 1'b1;
    bus.lsu_addr  = 32'h0000_1000;
    bus.lsu_wdata = 32'hDEAD_BEEF;
    bus.lsu_wmask = 4'hF;
    @(negedge clk);
    check1("prio_lsu_ready", bus.lsu_ready, 1'b1);
    check1("prio_ifu_ready", bus.ifu_ready, 1'b0);
    check1("prio_if_stall", bus.if_stall, 1'b1);
    expect_resp(1'b1, 32'h0);
    tick();
    bus.lsu_req       = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    check1("prio_mem_wen", bus.mem_wen, 1'b1);
    check32("prio_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check1("prio_if_stall_req", bus.if_stall, 1'b1);
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    @(negedge clk);
    check1("prio_lsu_rvalid", bus.lsu_rvalid, 1'b1);
    check1("prio_ifu_wait", bus.ifu_ready, 1'b0);
    check1("prio_if_stall_wait", bus.if_stall, 1'b1);
    tick();
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    check1("prio_ifu_ready", bus.ifu_ready, 1'b1);
    check1("prio_mem_stall_clr", bus.mem_stall, 1'b0);
    expect_resp(1'b0, 32'h1111_1111);
    tick();
    bus.ifu_req       = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    check1("prio_ifu_wen", bus.mem_wen, 1'b0);
    check32("prio_ifu_addr", bus.mem_addr, 32'h8000_0100);
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h1111_1111;
    @(negedge clk);
    check1("prio_ifu_rvalid", bus.ifu_rvalid, 1'b1);
    tick();
    clear_inputs();

    // Flush during WAIT: response swallowed, stall released next cycle
    bus.ifu_req  = 1'b1;
    bus.ifu_addr = 32'h8000_0200;
    @(negedge clk);
    check1("flush_grant", bus.ifu_ready, 1'b1);
    tick();
    bus.ifu_req       = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    bus.ifu_flush     = 1'b1;
    @(negedge clk);
    check1("flush_stall_same", bus.if_stall, 1'b1);
    tick();
    bus.ifu_flush      = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h1234_5678;
    @(negedge clk);
    check1("flush_no_rvalid", bus.ifu_rvalid, 1'b0);
    check1("flush_stall_drop", bus.if_stall, 1'b0);
    tick();
    clear_inputs();
    run_txn(vecs[0]);

    // Reset in WAIT, stale response afterwards must be ignored
    bus.lsu_req  = 1'b1;
    bus.lsu_addr = 32'h0000_4000;
    @(negedge clk);
    check1("rstw_grant", bus.lsu_ready, 1'b1);
    tick();
    bus.lsu_req       = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check1("rstw_lsu_rvalid", bus.lsu_rvalid, 1'b0);
    check1("rstw_req_valid", bus.mem_req_valid, 1'b0);
    tick();
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hBAD0_BAD0;
    @(negedge clk);
    check1("stale_lsu_rvalid", bus.lsu_rvalid, 1'b0);
    check32("stale_mem_addr", bus.mem_addr, 32'h0);
    check1("stale_mem_stall", bus.mem_stall, 1'b0);
    tick();
    clear_inputs();
    run_txn(vecs[1]);

    // No response: watchdog abort, or indefinite wait when compiled out
    bus.lsu_req  = 1'b1;
    bus.lsu_addr = 32'h0000_3000;
    @(negedge clk);
    check1("to_grant", bus.lsu_ready, 1'b1);
`ifdef MEM_ARB_TIMEOUT_EN
    expect_resp(1'b1, 32'h0);
`endif
    tick();
    bus.lsu_req       = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int k = 2; k < 8; k++) begin
      @(negedge clk);
      check1("to_no_err_early", bus.bus_err, 1'b0);
      check1("to_no_rvalid_early", bus.lsu_rvalid, 1'b0);
      tick();
    end
    @(negedge clk);
    check1("to_bus_err", bus.bus_err, 1'b1);
    check1("to_lsu_rvalid", bus.lsu_rvalid, 1'b1);
    tick();
    @(negedge clk);
    check1("to_err_pulse", bus.bus_err, 1'b0);
    check1("to_idle", bus.mem_stall, 1'b0);
    tick();
`else
    for (int k = 2; k < 22; k++) begin
      @(negedge clk);
      check1("nto_bus_err", bus.bus_err, 1'b0);
      check1("nto_stall", bus.mem_stall, 1'b1);
      tick();
    end
    expect_resp(1'b1, 32'h55AA_55AA);
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h55AA_55AA;
    @(negedge clk);
    check1("nto_late_rvalid", bus.lsu_rvalid, 1'b1);
    tick();
`endif
    clear_inputs();
    repeat (2) tick();

    check32("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single shared memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU) of the 5-stage core.
- One transaction is outstanding at a time. A 3-state FSM sequences each transaction.
- Produces if_stall and mem_stall for the pipeline stall/enable controller.
- LSU has fixed priority over IFU, so an older instruction always completes first.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; the write mask is DATA_W/8 bits
- TIMEOUT, 255, watchdog limit in cycles; used only when MEM_ARB_TIMEOUT_EN is defined

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ifu_req  in  1  IFU read request; held with ifu_addr until ifu_ready
- ifu_addr  in  ADDR_W  fetch address
- ifu_flush  in  1  discard the outstanding IFU response (redirect)
- ifu_ready  out  1  grant/accept pulse for IFU
- ifu_rvalid  out  1  IFU read data valid, 1-cycle pulse
- ifu_rdata  out  DATA_W  IFU read data
- lsu_req  in  1  LSU request; held with payload until lsu_ready
- lsu_wen  in  1  1 = write, 0 = read
- lsu_addr  in  ADDR_W  access address
- lsu_wdata  in  DATA_W  write data
- lsu_wmask  in  DATA_W/8  byte write strobes
- lsu_ready  out  1  grant/accept pulse for LSU
- lsu_rvalid  out  1  LSU completion pulse (read data or write acknowledge)
- lsu_rdata  out  DATA_W  LSU read data
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts request
- mem_addr  out  ADDR_W  registered address
- mem_wen  out  1  registered write enable
- mem_wdata  out  DATA_W  registered write data
- mem_wmask  out  DATA_W/8  registered write mask
- mem_resp_valid  in  1  downstream response / write acknowledge
- mem_rdata  in  DATA_W  downstream read data
- bus_err  out  1  timeout abort pulse; tied 0 without MEM_ARB_TIMEOUT_EN
- if_stall  out  1  IFU waiting on memory
- mem_stall  out  1  LSU waiting on memory

Behaviour:
- FSM states are IDLE, REQ and WAIT. Registers: owner (0 = IFU, 1 = LSU), drop (flush pending), payload registers.
- Reset: state = IDLE, owner = 0, drop = 0, payload registers = 0. All outputs are 0 (the stall outputs still follow the stall equations below). Reset applies mid-transaction; after reset, mem_resp_valid seen in IDLE is ignored.
- IDLE, grant:
  - lsu_req=1 → lsu_ready=1 combinationally; latch LSU payload; owner=1; go to REQ.
  - Otherwise ifu_req=1 → ifu_ready=1; latch ifu_addr with wen=0 and wmask=0; owner=0; go to REQ.
  - Both requesting in the same cycle → LSU wins. The IFU stays pending and is granted in a later IDLE cycle.
- REQ:
  - mem_req_valid=1, driven from the payload registers, stable until mem_req_ready.
  - Handshake (valid and ready both 1) → go to WAIT.
  - mem_resp_valid in REQ is ignored; downstream returns responses no earlier than the cycle after the handshake.
- WAIT:
  - On mem_resp_valid, return to IDLE.
  - If owner=1: lsu_rvalid=1 and lsu_rdata=mem_rdata, combinational pass-through.
  - If owner=0 and drop=0: ifu_rvalid=1 and ifu_rdata=mem_rdata.
  - If owner=0 and drop=1: the response is consumed silently and drop is cleared.
- Flush:
  - ifu_flush while state is REQ or WAIT with owner=0 sets drop.
  - ifu_flush in the same cycle as the response suppresses ifu_rvalid.
  - ifu_flush has no effect in IDLE or when owner=1.
- Minimum latency: grant at T, handshake at T+1, response at T+2 (rvalid at T+2), next grant possible at T+3.
- Stall equations:
  - if_stall = (ifu_req | (state≠IDLE & owner=0 & ~drop)) & ~ifu_rvalid
  - mem_stall = (lsu_req | (state≠IDLE & owner=1)) & ~lsu_rvalid
- Read data outputs are 0 whenever the matching rvalid is 0.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - A cycle counter clears on grant and increments in REQ and WAIT.
  - When it reaches TIMEOUT: abort to IDLE, pulse bus_err for 1 cycle, and pulse the owner's rvalid with rdata=0. Drop is still honoured for the IFU.
  - If a response arrives in the same cycle as the timeout, the response wins and bus_err stays 0.
  - A late response arriving in IDLE is ignored.
- MEM_ARB_TIMEOUT_EN undefined: no counter, bus_err=0, and the arbiter waits indefinitely.

Test Plan:
- IFU read 0x8000_0000, with mem_req_ready=1 at the first REQ cycle and a response at the next cycle returning 0x0000_0413 → ifu_ready at T, mem_req_valid at T+1, ifu_rvalid with 0x0000_0413 at T+2, if_stall high for T..T+1 only.
- ifu_req and lsu_req (write 0x1000, wdata 0xDEADBEEF, wmask 0xF) in the same cycle → LSU granted first with mem_wen=1; IFU granted in the IDLE cycle after lsu_rvalid; if_stall held throughout.
- mem_req_ready held low 5 cycles in REQ → mem_addr, mem_wdata and mem_wmask unchanged, mem_req_valid stays 1, no state advance.
- ifu_flush during WAIT, then response 0x12345678 → ifu_rvalid stays 0, if_stall drops the cycle after the flush, the next ifu_req is granted normally.
- rst asserted in WAIT, then a stale mem_resp_valid arrives → all outputs 0, no rvalid, and the first new request is granted cleanly.
- MEM_ARB_TIMEOUT_EN with TIMEOUT=8 and no response → bus_err and lsu_rvalid pulse with rdata=0 exactly 8 cycles after grant; state returns to IDLE.
